// File: rtl/bsg_gateway_wh_packet_rr_arbiter_if.sv
// bsg_gateway_wh_packet_rr_arbiter_if: input-stream and output-link wormhole handshake bundle
interface bsg_gateway_wh_packet_rr_arbiter_if #(
  parameter int num_in_p = 4,
  parameter int flit_width_p = 32
);
  localparam int id_width_lp = $clog2(num_in_p);
  logic [num_in_p-1:0] v_i;
  logic [num_in_p*flit_width_p-1:0] data_i;
  logic [num_in_p-1:0] ready_and_o;
  logic v_o;
  logic [flit_width_p-1:0] data_o;
  logic ready_and_i;
  logic [id_width_lp-1:0] grant_id_o;
  logic busy_o;
  modport slave (input v_i, data_i, ready_and_i, output ready_and_o, v_o, data_o, grant_id_o, busy_o);
  modport master (output v_i, data_i, ready_and_i, input ready_and_o, v_o, data_o, grant_id_o, busy_o);
endinterface

// File: rtl/bsg_gateway_wh_packet_rr_arbiter.sv
// bsg_gateway_wh_packet_rr_arbiter: packet-atomic round-robin share of one wormhole link
module bsg_gateway_wh_packet_rr_arbiter #(
  parameter int num_in_p = 4,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 7,
  parameter int len_width_p = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_gateway_wh_packet_rr_arbiter_if.slave link
);
  localparam int lg_lp = $clog2(num_in_p);
  localparam logic [lg_lp:0] n_lp = (lg_lp+1)'(num_in_p);
  typedef enum logic [1:0] {idle_s, hold_s, body_s} state_e;
  state_e state_r, state_n;
  logic [lg_lp-1:0] grant_r, grant_n, ptr_r, ptr_n, winner, gid, idx;
  logic [len_width_p-1:0] cnt_r, cnt_n, len;
  logic [flit_width_p-1:0] flit;
  logic [lg_lp:0] sum;
  logic accept;

  function automatic logic [lg_lp-1:0] inc(input logic [lg_lp-1:0] x);
    return (x == lg_lp'(num_in_p-1)) ? '0 : x + 1'b1;
  endfunction

  // scan from lowest priority up so the stream closest to ptr_r wins last
  always_comb begin
    winner = ptr_r;
    sum = '0;
    idx = '0;
    for (int i = num_in_p-1; i >= 0; i--) begin
      sum = {1'b0, ptr_r} + (lg_lp+1)'(i);
      idx = (sum >= n_lp) ? lg_lp'(sum - n_lp) : lg_lp'(sum);
      if (link.v_i[idx]) winner = idx;
    end
  end

  assign gid = reset_i ? '0 : (state_r == idle_s ? winner : grant_r);
  assign flit = link.data_i[gid*flit_width_p +: flit_width_p];
  assign len = flit[cord_width_p +: len_width_p];
  assign link.data_o = flit;
  assign link.grant_id_o = gid;
  assign link.v_o = ~reset_i & link.v_i[gid];
  assign link.ready_and_o = reset_i ? '0 : (num_in_p'(link.ready_and_i) << gid);
  assign link.busy_o = ~reset_i & (state_r != idle_s);
  assign accept = link.v_o & link.ready_and_i;

  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    ptr_n = ptr_r;
    cnt_n = cnt_r;
    unique case (state_r)
      idle_s: if (link.v_o) begin
        grant_n = winner;
        state_n = !accept ? hold_s : (len == '0 ? idle_s : body_s);
        cnt_n = accept ? len : cnt_r;
        ptr_n = (accept && len == '0) ? inc(winner) : ptr_r;
      end
      hold_s: if (accept) begin
        state_n = (len == '0) ? idle_s : body_s;
        cnt_n = len;
        ptr_n = (len == '0) ? inc(grant_r) : ptr_r;
      end
      body_s: if (accept) begin
        cnt_n = cnt_r - 1'b1;
        state_n = (cnt_r == len_width_p'(1)) ? idle_s : body_s;
        ptr_n = (cnt_r == len_width_p'(1)) ? inc(grant_r) : ptr_r;
      end
      default: state_n = idle_s;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= idle_s;
      grant_r <= '0;
      ptr_r <= '0;
      cnt_r <= '0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      ptr_r <= ptr_n;
      cnt_r <= cnt_n;
    end
  end
endmodule

// File: tb/tb_bsg_gateway_wh_packet_rr_arbiter.sv
// tb_bsg_gateway_wh_packet_rr_arbiter: directed checks of grant order, packet locking and reset
module tb_bsg_gateway_wh_packet_rr_arbiter;
  typedef struct packed {
    logic [3:0] v;
    logic rdy;
    logic [1:0] gid;
    logic vo;
    logic busy;
    logic [3:0] rdy_o;
  } vec_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int checks = 0;
  int fails = 0;
  int lens [4] = '{0, 0, 0, 0};
  int pos [4] = '{0, 0, 0, 0};
  int pkt [4] = '{0, 0, 0, 0};

  bsg_gateway_wh_packet_rr_arbiter_if #(.num_in_p(4), .flit_width_p(32)) link ();

  bsg_gateway_wh_packet_rr_arbiter #(.num_in_p(4), .flit_width_p(32), .cord_width_p(7), .len_width_p(4)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .link(link)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flit(int k, int p, int q, int l);
    return (q == 0) ? {4'(k), 4'(p), 13'h0, 4'(l), 7'h0} : {4'(k), 4'(p), 8'(q), 16'hbeef};
  endfunction

  always_comb begin
    link.data_i = '0;
    for (int k = 0; k < 4; k++) link.data_i[k*32 +: 32] = flit(k, pkt[k], pos[k], lens[k]);
  end

  // upstream sources: each stream emits back-to-back packets of lens[k] body flits
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset_i) begin
        pos[k] <= 0;
        pkt[k] <= 0;
      end else if (link.v_i[k] && link.ready_and_o[k]) begin
        pos[k] <= (pos[k] == lens[k]) ? 0 : pos[k] + 1;
        pkt[k] <= (pos[k] == lens[k]) ? pkt[k] + 1 : pkt[k];
      end
    end
  end

  task automatic test_reset();
    logic [6:0] got;
    reset_i = 1'b1;
    link.v_i = 4'hf;
    link.ready_and_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o};
      checks++;
      if (got !== 7'h0) begin
        fails++;
        $display("FAIL reset c%0d: got %h want 00", i, got);
      end
      @(posedge clk);
      #1;
    end
    reset_i = 1'b0;
    link.v_i = '0;
  endtask

  task automatic run_pkt_check(string name, int k, int want);
    checks++;
    if (pkt[k] !== want) begin
      fails++;
      $display("FAIL %s pkt[%0d]: got %0d want %0d", name, k, pkt[k], want);
    end
  endtask

  task automatic test_single();
    vec_t t [5] = '{
      '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100},
      '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100},
      '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100},
      '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100},
      '{4'b1001, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000}};
    logic [39:0] got, exp;
    lens = '{0, 0, 3, 0};
    for (int i = 0; i < 5; i++) begin
      link.v_i = t[i].v;
      link.ready_and_i = t[i].rdy;
      @(negedge clk);
      exp = {t[i].gid, t[i].vo, t[i].busy, t[i].rdy_o, flit(t[i].gid, pkt[t[i].gid], pos[t[i].gid], lens[t[i].gid])};
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o, link.data_o};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL single c%0d: got %h want %h", i, got, exp);
      end
      @(posedge clk);
      #1;
    end
    run_pkt_check("single", 2, 1);
  endtask

  task automatic test_round_robin();
    vec_t t [10];
    logic [39:0] got, exp;
    lens = '{1, 1, 1, 1};
    for (int i = 0; i < 10; i++) t[i] = '{4'hf, 1'b1, 2'((i/2) % 4), 1'b1, 1'(i % 2), 4'(1 << ((i/2) % 4))};
    for (int i = 0; i < 10; i++) begin
      link.v_i = t[i].v;
      link.ready_and_i = t[i].rdy;
      @(negedge clk);
      exp = {t[i].gid, t[i].vo, t[i].busy, t[i].rdy_o, flit(t[i].gid, pkt[t[i].gid], pos[t[i].gid], lens[t[i].gid])};
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o, link.data_o};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL round_robin c%0d: got %h want %h", i, got, exp);
      end
      @(posedge clk);
      #1;
    end
    run_pkt_check("round_robin", 0, 2);
    run_pkt_check("round_robin", 3, 1);
  endtask

  task automatic test_hold();
    vec_t t [9] = '{
      '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000},
      '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0000},
      '{4'b0011, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0000},
      '{4'b0011, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0000},
      '{4'b0011, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0000},
      '{4'b0011, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010},
      '{4'b0011, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010},
      '{4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001},
      '{4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001}};
    logic [39:0] got, exp;
    lens = '{0, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      link.v_i = t[i].v;
      link.ready_and_i = t[i].rdy;
      @(negedge clk);
      exp = {t[i].gid, t[i].vo, t[i].busy, t[i].rdy_o, flit(t[i].gid, pkt[t[i].gid], pos[t[i].gid], lens[t[i].gid])};
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o, link.data_o};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL hold c%0d: got %h want %h", i, got, exp);
      end
      @(posedge clk);
      #1;
    end
    run_pkt_check("hold", 1, 1);
    run_pkt_check("hold", 0, 2);
  endtask

  task automatic test_stall_wrap();
    vec_t t [8] = '{
      '{4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 4'b1000},
      '{4'b1001, 1'b1, 2'd3, 1'b1, 1'b1, 4'b1000},
      '{4'b0001, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1000},
      '{4'b0001, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1000},
      '{4'b0001, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1000},
      '{4'b1001, 1'b1, 2'd3, 1'b1, 1'b1, 4'b1000},
      '{4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001},
      '{4'b1001, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000}};
    logic [39:0] got, exp;
    lens = '{0, 0, 0, 2};
    for (int i = 0; i < 8; i++) begin
      link.v_i = t[i].v;
      link.ready_and_i = t[i].rdy;
      @(negedge clk);
      exp = {t[i].gid, t[i].vo, t[i].busy, t[i].rdy_o, flit(t[i].gid, pkt[t[i].gid], pos[t[i].gid], lens[t[i].gid])};
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o, link.data_o};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL stall_wrap c%0d: got %h want %h", i, got, exp);
      end
      @(posedge clk);
      #1;
    end
    run_pkt_check("stall_wrap", 3, 1);
    run_pkt_check("stall_wrap", 0, 1);
  endtask

  task automatic test_back_to_back();
    vec_t t [4] = '{
      '{4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001},
      '{4'b0011, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010},
      '{4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001},
      '{4'b0011, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010}};
    logic [39:0] got, exp;
    lens = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      link.v_i = t[i].v;
      link.ready_and_i = t[i].rdy;
      @(negedge clk);
      exp = {t[i].gid, t[i].vo, t[i].busy, t[i].rdy_o, flit(t[i].gid, pkt[t[i].gid], pos[t[i].gid], lens[t[i].gid])};
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o, link.data_o};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL back_to_back c%0d: got %h want %h", i, got, exp);
      end
      @(posedge clk);
      #1;
    end
    run_pkt_check("back_to_back", 0, 2);
    run_pkt_check("back_to_back", 1, 2);
  endtask

  task automatic test_reset_mid_packet();
    vec_t t [4] = '{
      '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100},
      '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100},
      '{4'b0101, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001},
      '{4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000}};
    logic [39:0] got, exp;
    lens = '{0, 0, 6, 0};
    for (int i = 0; i < 4; i++) begin
      if (i == 2) test_reset();
      link.v_i = t[i].v;
      link.ready_and_i = t[i].rdy;
      @(negedge clk);
      exp = {t[i].gid, t[i].vo, t[i].busy, t[i].rdy_o, flit(t[i].gid, pkt[t[i].gid], pos[t[i].gid], lens[t[i].gid])};
      got = {link.grant_id_o, link.v_o, link.busy_o, link.ready_and_o, link.data_o};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL reset_mid c%0d: got %h want %h", i, got, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    link.v_i = '0;
    link.ready_and_i = 1'b0;
    test_reset();
    test_single();
    test_reset();
    test_round_robin();
    test_reset();
    test_hold();
    test_reset();
    test_stall_wrap();
    test_reset();
    test_back_to_back();
    test_reset();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
